// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider (DIV/DIVU) returning {remainder, quotient}
// clk        rising-edge clock
// rst        synchronous reset, active-low
// div_valid  start request (accepted only in IDLE)
// signed_div 1 = signed divide, sampled with div_valid
// a, b       dividend, divisor
// annul      cancel the in-flight operation
// stall_div  pipeline stall request
// ready      one-cycle result-valid pulse
// result     {remainder, quotient}
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_valid,
   input  logic        signed_div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        annul,
   output logic        stall_div,
   output logic        ready,
   output logic [63:0] result
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t      r_state, w_next;
   logic [4:0]  r_count;
   logic [31:0] r_rem, r_quo, r_dvsr, r_a;
   logic        r_neg_q, r_neg_r, r_div0;
   logic [63:0] r_result;
   logic        w_accept, w_ge;
   logic [32:0] w_rem_sh;
   logic [31:0] w_trial, w_q, w_r;
   // the quotient register doubles as the dividend shifter: its MSB feeds the remainder
   assign w_rem_sh = {r_rem, r_quo[31]};
   assign w_ge     = w_rem_sh >= {1'b0, r_dvsr};
   // remainder < divisor keeps the real difference within 32 bits
   assign w_trial  = w_rem_sh[31:0] - r_dvsr;
   assign w_q      = r_div0 ? 32'hFFFF_FFFF : r_neg_q ? -r_quo : r_quo;
   assign w_r      = r_div0 ? r_a : r_neg_r ? -r_rem : r_rem;
   always_comb begin
      w_accept  = r_state == IDLE && div_valid && !annul;
      w_next    = r_state;
      if (annul) w_next = IDLE;
      else if (w_accept) w_next = BUSY;
      else if (r_state == BUSY && r_count == 5'd31) w_next = DONE;
      else if (r_state == DONE) w_next = IDLE;
      stall_div = w_accept || r_state == BUSY;
      ready     = r_state == DONE && !annul;
      // an annulled DONE must leave the visible result untouched
      result    = ready ? {w_r, w_q} : r_result;
   end
   always_ff @(posedge clk) begin
      if (!rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count  <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvsr   <= '0;
         r_a      <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= signed_div && a[31] ? -a : a;
            r_dvsr  <= signed_div && b[31] ? -b : b;
            r_a     <= a;
            r_neg_q <= signed_div && (a[31] ^ b[31]);
            r_neg_r <= signed_div && a[31];
            r_div0  <= b == 32'd0;
         end else if (r_state == BUSY) begin
            r_count <= r_count + 5'd1;
            r_rem   <= w_ge ? w_trial : w_rem_sh[31:0];
            r_quo   <= {r_quo[30:0], w_ge};
         end
         if (ready) r_result <= {w_r, w_q};
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized self-checking bench for div_unit against an arithmetic reference model
module tb_div_unit;
   logic        clk = 1'b0, rst = 1'b0, div_valid = 1'b0, signed_div = 1'b0, annul = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        stall_div, ready;
   logic [63:0] result;
   int          n_cmp = 0, n_err = 0;
   logic [63:0] last_res = '0;
   always #5 clk = ~clk;
   div_unit dut (
      .clk(clk), .rst(rst), .div_valid(div_valid), .signed_div(signed_div),
      .a(a), .b(b), .annul(annul), .stall_div(stall_div), .ready(ready), .result(result)
   );
   function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
      longint q, r;
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (s) begin
         q = longint'($signed(x)) / longint'($signed(y));
         r = longint'($signed(x)) % longint'($signed(y));
      end else begin
         q = longint'(x) / longint'(y);
         r = longint'(x) % longint'(y);
      end
      return {r[31:0], q[31:0]};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // starts an operation in the current cycle and observes 36 following cycles
   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [63:0] res, output int lat, output int pulses, output int stall_bad);
      res = '0; lat = -1; pulses = 0; stall_bad = 0;
      a = x; b = y; signed_div = s; div_valid = 1'b1; annul = 1'b0;
      @(negedge clk);
      if (stall_div !== 1'b1 || ready !== 1'b0) stall_bad++;
      for (int k = 1; k <= 36; k++) begin
         tick();
         div_valid = 1'b0; a = $urandom; b = $urandom; signed_div = 1'($urandom);
         @(negedge clk);
         if (ready === 1'b1) begin
            pulses++; lat = k; res = result;
         end
         if (stall_div !== (k <= 32)) stall_bad++;
      end
      tick();
   endtask
   task automatic test_reset();
      rst = 1'b0; div_valid = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", ready); end
      n_cmp++; if (result !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
      n_cmp++; if (stall_div !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall_div); end
      tick();
      rst = 1'b1;
      tick();
   endtask
   task automatic test_directed();
      logic [31:0] ta [7] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB};
      logic [31:0] tb [7] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
      logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [63:0] res, exp_res;
      int          lat, pulses, sb;
      for (int i = 0; i < 7; i++) begin
         exp_res = model(ta[i], tb[i], ts[i]);
         run_op(ta[i], tb[i], ts[i], res, lat, pulses, sb);
         n_cmp++; if (res !== exp_res) begin n_err++; $display("FAIL dir%0d_result: got %h expected %h", i, res, exp_res); end
         n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL dir%0d_latency: got %0d expected 33", i, lat); end
         n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL dir%0d_pulses: got %0d expected 1", i, pulses); end
         n_cmp++; if (sb !== 0) begin n_err++; $display("FAIL dir%0d_stall: got %0d bad cycles expected 0", i, sb); end
         last_res = exp_res;
      end
   endtask
   task automatic test_random();
      logic [31:0] x, y;
      logic        s;
      logic [63:0] res, exp_res;
      int          lat, pulses, sb, sel;
      for (int i = 0; i < 20; i++) begin
         x = $urandom; s = 1'($urandom); sel = $urandom_range(0, 3);
         y = sel == 0 ? 32'd0 : sel == 1 ? 32'($urandom_range(1, 15)) : sel == 2 ? $urandom : -32'($urandom_range(1, 15));
         exp_res = model(x, y, s);
         run_op(x, y, s, res, lat, pulses, sb);
         n_cmp++; if (res !== exp_res) begin n_err++; $display("FAIL rnd%0d_result a=%h b=%h s=%b: got %h expected %h", i, x, y, s, res, exp_res); end
         n_cmp++; if (lat !== 33 || pulses !== 1 || sb !== 0) begin n_err++; $display("FAIL rnd%0d_timing: got lat=%0d pulses=%0d stallbad=%0d expected 33/1/0", i, lat, pulses, sb); end
         last_res = exp_res;
      end
   endtask
   task automatic test_back_to_back();
      logic [31:0] x1, y1, x2, y2;
      logic        s1, s2, st33, st34;
      logic [63:0] r1, r2, e1, e2;
      int          pulses;
      x1 = $urandom; y1 = 32'($urandom_range(1, 1000)); s1 = 1'($urandom);
      x2 = '0; y2 = '0; s2 = 1'b0; r1 = '0; r2 = '0; st33 = 1'bx; st34 = 1'bx; pulses = 0;
      a = x1; b = y1; signed_div = s1; div_valid = 1'b1; annul = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 70; k++) begin
         tick();
         a = $urandom; b = 32'($urandom_range(1, 1000)); signed_div = 1'($urandom); div_valid = k <= 34;
         if (k == 34) begin x2 = a; y2 = b; s2 = signed_div; end
         @(negedge clk);
         if (k == 33) st33 = stall_div;
         if (k == 34) st34 = stall_div;
         if (ready === 1'b1) begin
            pulses++;
            if (k == 33) r1 = result;
            else if (k == 67) r2 = result;
         end
      end
      tick();
      e1 = model(x1, y1, s1);
      e2 = model(x2, y2, s2);
      n_cmp++; if (r1 !== e1) begin n_err++; $display("FAIL b2b_first: got %h expected %h", r1, e1); end
      n_cmp++; if (r2 !== e2) begin n_err++; $display("FAIL b2b_second: got %h expected %h", r2, e2); end
      n_cmp++; if (pulses !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
      n_cmp++; if (st33 !== 1'b0) begin n_err++; $display("FAIL b2b_stall_done: got %b expected 0", st33); end
      n_cmp++; if (st34 !== 1'b1) begin n_err++; $display("FAIL b2b_accept_n34: got %b expected 1", st34); end
      last_res = e2;
   endtask
   task automatic test_annul();
      logic [63:0] res, prev;
      int          bad_ready, bad_res, lat, pulses, sb;
      prev = last_res; bad_ready = 0; bad_res = 0;
      a = 32'd100; b = 32'd7; signed_div = 1'b0; div_valid = 1'b1; annul = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 10; k++) begin
         tick();
         div_valid = 1'b0; annul = k == 10; a = $urandom; b = $urandom;
         @(negedge clk);
         if (ready !== 1'b0) bad_ready++;
      end
      tick();
      annul = 1'b0;
      @(negedge clk);
      n_cmp++; if (stall_div !== 1'b0) begin n_err++; $display("FAIL annul_stall_k1: got %b expected 0", stall_div); end
      for (int k = 0; k < 40; k++) begin
         if (ready !== 1'b0) bad_ready++;
         if (result !== prev) bad_res++;
         tick();
         @(negedge clk);
      end
      tick();
      n_cmp++; if (bad_ready !== 0) begin n_err++; $display("FAIL annul_no_ready: got %0d pulses expected 0", bad_ready); end
      n_cmp++; if (bad_res !== 0) begin n_err++; $display("FAIL annul_result_hold: got %0d changed cycles expected 0", bad_res); end
      a = 32'd100; b = 32'd7; signed_div = 1'b0; div_valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         div_valid = 1'b0; annul = k == 10;
      end
      tick();
      run_op(32'd9, 32'd3, 1'b0, res, lat, pulses, sb);
      n_cmp++; if (res !== model(32'd9, 32'd3, 1'b0)) begin n_err++; $display("FAIL annul_reissue_result: got %h expected %h", res, model(32'd9, 32'd3, 1'b0)); end
      n_cmp++; if (lat !== 33 || pulses !== 1 || sb !== 0) begin n_err++; $display("FAIL annul_reissue_timing: got lat=%0d pulses=%0d stallbad=%0d expected 33/1/0", lat, pulses, sb); end
      last_res = model(32'd9, 32'd3, 1'b0);
   endtask
   task automatic test_reset_mid();
      int bad_ready;
      bad_ready = 0;
      a = $urandom; b = 32'($urandom_range(1, 100)); signed_div = 1'($urandom); div_valid = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick();
         div_valid = 1'b0; rst = k != 15;
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready: got %b expected 0", ready); end
      n_cmp++; if (result !== 64'd0) begin n_err++; $display("FAIL rstmid_result: got %h expected 0", result); end
      n_cmp++; if (stall_div !== 1'b0) begin n_err++; $display("FAIL rstmid_stall: got %b expected 0", stall_div); end
      for (int k = 0; k < 40; k++) begin
         tick();
         @(negedge clk);
         if (ready !== 1'b0) bad_ready++;
      end
      n_cmp++; if (bad_ready !== 0) begin n_err++; $display("FAIL rstmid_no_ready: got %0d pulses expected 0", bad_ready); end
      tick();
      last_res = '0;
   endtask
   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_annul();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
